prv32_muldiv_ctrl: RTL and testbench
====================================

PRV32_MULDIV_CTRL -- requirements
Module: prv32_muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed at 32 bits.
REQ-002 clk  input  1  system clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request pulse; sampled only in IDLE.
REQ-005 op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 rs1, rs2  input  32 each  operands; captured on the start-accept edge.
REQ-007 busy  output  1  high in PREP, ITER, FIX.
REQ-008 done  output  1  one-cycle completion pulse.
REQ-009 result  output  32  final value; held from DONE until the next accepted start.
REQ-010 alu_a, alu_b  output  32 each  operands to the shared ALU.
REQ-011 alu_fn  output  4  ALU function: 4'b0000 add, 4'b0001 sub.
REQ-012 alu_r  input  32  ALU result.
REQ-013 alu_cf  input  1  ALU carry; for sub, 1 means no borrow.

Function
REQ-014 The FSM SHALL have the states IDLE, PREP, ITER, FIX and DONE, with transitions IDLE->PREP on start, PREP->ITER, ITER->FIX after 32 ITER cycles, FIX->DONE, and DONE->IDLE unconditionally.
REQ-015 start outside IDLE, including in DONE, SHALL be ignored with no side effect.
REQ-016 PREP SHALL register the magnitudes of signed operands internally: rs1 for MUL, MULH, MULHSU, DIV and REM, and rs2 for MUL, MULH, DIV and REM; it SHALL also record the result sign.
REQ-017 Multiply ITER step k SHALL:
  - drive alu_fn=add, alu_a=hi, alu_b=multiplicand;
  - if lo[0]=1, set {hi,lo} <= {alu_cf, alu_r, lo[31:1]};
  - otherwise shift {hi,lo} right by 1 with zero fill.
REQ-018 Divide ITER step SHALL:
  - form {msb, rem_sh} = {rem, quot[31]};
  - drive alu_fn=sub, alu_a=rem_sh, alu_b=divisor;
  - if (alu_cf | msb), set rem <= alu_r and shift 1 into quot; otherwise set rem <= rem_sh and shift 0 into quot.
REQ-019 FIX SHALL negate the selected word when the recorded sign requires it and SHALL select:
  - MUL: low word;
  - MULH, MULHSU, MULHU: high word;
  - DIV, DIVU: quotient;
  - REM, REMU: remainder.
  The remainder sign SHALL follow the sign of rs1.
REQ-020 For divide by zero, the quotient SHALL be 0xFFFFFFFF and the remainder SHALL be rs1.
REQ-021 For DIV or REM of 0x80000000 by 0xFFFFFFFF, the quotient SHALL be 0x80000000 and the remainder SHALL be 0.
REQ-022 Latency SHALL be as follows:
  - done SHALL be high only in DONE;
  - DONE SHALL be entered on edge e0+34, where e0 is the start-accept edge;
  - busy SHALL be high for cycles e0+1 through e0+34.
REQ-023 Outside ITER, the block SHALL drive alu_fn=0000 and alu_a=alu_b=0.
REQ-024 result SHALL update only on the FIX->DONE edge, or on the early-out PREP->DONE edge.

Reset
REQ-025 On rst_n=0 the block SHALL immediately:
  - enter state IDLE;
  - set busy=0, done=0 and result=0;
  - set alu_a=alu_b=0 and alu_fn=0;
  - clear all internal registers.
REQ-026 Reset mid-operation SHALL abandon the operation without producing a done pulse.
REQ-027 After rst_n deasserts, the first accepted start SHALL behave identically to one issued after power-up.

Configuration
REQ-028 The block SHALL support the macro PRV32_MULDIV_EARLY_OUT_EN.
REQ-029 With PRV32_MULDIV_EARLY_OUT_EN defined, divide by zero and signed divide overflow SHALL go PREP->DONE:
  - done SHALL be high after edge e0+1;
  - no ALU cycles SHALL be used;
  - the result values SHALL be those in REQ-020 and REQ-021.
REQ-030 Without PRV32_MULDIV_EARLY_OUT_EN, all operations SHALL take the full latency of REQ-022 and SHALL produce the same values.

Verification
REQ-031 Multiply:
  - MUL 7 x 6 -> result 0x0000002A, done exactly after edge e0+34, busy high 34 cycles.
  - MULH 0xFFFFFFFD x 2 -> 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-032 Signed divide: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM of the same operands -> 0xFFFFFFFF.
REQ-033 Unsigned divide: DIVU 0xFFFFFFFF / 0x80000001 -> 0x00000001; REMU of the same operands -> 0x7FFFFFFE.
REQ-034 Divide by zero:
  - DIVU 5 / 0 -> 0xFFFFFFFF;
  - REM 5 / 0 -> 0x00000005;
  - done after e0+1 with the macro, e0+34 without.
REQ-035 Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
REQ-036 Control boundaries:
  - start pulsed during ITER -> ignored, with the first result unchanged;
  - rst_n low at ITER step 10 -> busy=0, result=0, no done;
  - a new MUL 3 x 3 after reset -> 9.

Source files
------------

// File: rtl/prv32_muldiv_ctrl.sv
// prv32_muldiv_ctrl: iterative RV32M multiply/divide sequencer built around a shared external ALU.
// Multiplication is shift-and-add over magnitudes. Division is restoring division over magnitudes.
// Signs are applied in FIX.
//
// Optional feature: define PRV32_MULDIV_EARLY_OUT_EN to finish divide-by-zero and signed
// divide overflow directly from PREP, without using any ALU cycles.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, op, rs1, rs2 request pulse, RV32M funct3 and operands (sampled in IDLE only)
//   busy, done, result  busy in PREP/ITER/FIX, one-cycle done pulse, held result
//   alu_a, alu_b, alu_fn operands and function to the shared ALU (zero outside ITER)
//   alu_r, alu_cf       ALU result and carry (for sub, carry = no borrow)
module prv32_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_fn,
    input  logic [31:0] alu_r,
    input  logic        alu_cf
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned CNTW = 5;
    localparam logic [3:0]      FN_ADD    = 4'b0000;
    localparam logic [3:0]      FN_SUB    = 4'b0001;
    localparam logic [CNTW-1:0] LAST_STEP = CNTW'(31);

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

    state_t            state_q, state_n;
    logic [2:0]        op_q, op_n;
    logic [XLEN-1:0]   a_q, a_n, b_q, b_n;
    logic [XLEN-1:0]   hi_q, hi_n, lo_q, lo_n;     // {hi,lo} = product, or {rem,quot}
    logic [XLEN-1:0]   mcand_q, mcand_n;           // multiplicand or divisor magnitude
    logic              neg_q, neg_n, dz_q, dz_n;
    logic [CNTW-1:0]   cnt_q, cnt_n;
    logic [XLEN-1:0]   result_n, alu_a_n, alu_b_n;
    logic [3:0]        alu_fn_n;
    logic              busy_n, done_n;

    // Operand decode for the captured request.
    logic              is_div, a_signed, b_signed, a_neg, b_neg, b_zero, res_neg;
    logic [XLEN-1:0]   a_mag, b_mag;

    assign is_div   = op_q[2];
    assign a_signed = op_q[2] ? ~op_q[0] : (op_q[1:0] != 2'b11);
    assign b_signed = op_q[2] ? ~op_q[0] : ~op_q[1];
    assign a_neg    = a_signed & a_q[XLEN-1];
    assign b_neg    = b_signed & b_q[XLEN-1];
    assign a_mag    = a_neg ? (~a_q + XLEN'(1)) : a_q;
    assign b_mag    = b_neg ? (~b_q + XLEN'(1)) : b_q;
    assign b_zero   = (b_q == '0);
    // Remainder takes the dividend's sign; everything else takes the XOR of the operand signs.
    assign res_neg  = (is_div && op_q[1]) ? a_neg : (a_neg ^ b_neg);

`ifdef PRV32_MULDIV_EARLY_OUT_EN
    logic              ovf;
    logic [XLEN-1:0]   early_val;
    assign ovf       = a_signed & is_div & (a_q == {1'b1, {(XLEN-1){1'b0}}}) & (b_q == '1);
    assign early_val = op_q[1] ? (b_zero ? a_q : '0)
                               : (b_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}});
`endif

    // FIX: select the word and apply the recorded sign.
    logic              is_hi_mul;
    logic [XLEN-1:0]   sel, fix_val;

    always_comb begin
        is_hi_mul = !is_div && (op_q[1:0] != 2'b00);
        sel       = (is_div ? op_q[1] : is_hi_mul) ? hi_q : lo_q;
        fix_val   = sel;
        if (neg_q) begin
            // High word of a negated 64-bit product borrows the carry out of the low word.
            if (is_hi_mul) fix_val = ~hi_q + XLEN'(lo_q == '0);
            else           fix_val = ~sel + XLEN'(1);
        end
        // Signed quotient of a divide by zero is all ones whatever the dividend sign.
        if (is_div && !op_q[1] && dz_q) fix_val = '1;
    end

    // Next-state, datapath and output logic.
    always_comb begin
        state_n  = state_q;
        op_n     = op_q;
        a_n      = a_q;
        b_n      = b_q;
        hi_n     = hi_q;
        lo_n     = lo_q;
        mcand_n  = mcand_q;
        neg_n    = neg_q;
        dz_n     = dz_q;
        cnt_n    = cnt_q;
        result_n = result;
        alu_a_n  = '0;
        alu_b_n  = '0;
        alu_fn_n = FN_ADD;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_n = S_PREP;
                    op_n    = op;
                    a_n     = rs1;
                    b_n     = rs2;
                end
            end
            S_PREP: begin
                hi_n    = '0;
                lo_n    = a_mag;
                mcand_n = b_mag;
                neg_n   = res_neg;
                dz_n    = b_zero;
                cnt_n   = '0;
                state_n = S_ITER;
`ifdef PRV32_MULDIV_EARLY_OUT_EN
                if (is_div && (b_zero || ovf)) begin
                    state_n  = S_DONE;
                    result_n = early_val;
                end
`endif
            end
            S_ITER: begin
                if (is_div) begin
                    // Restoring step: hi[31] is the bit shifted out of the 33-bit partial remainder.
                    if (alu_cf || hi_q[XLEN-1]) begin
                        hi_n = alu_r;
                        lo_n = {lo_q[XLEN-2:0], 1'b1};
                    end else begin
                        hi_n = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
                        lo_n = {lo_q[XLEN-2:0], 1'b0};
                    end
                end else begin
                    if (lo_q[0]) {hi_n, lo_n} = {alu_cf, alu_r, lo_q[XLEN-1:1]};
                    else         {hi_n, lo_n} = {1'b0, hi_q, lo_q[XLEN-1:1]};
                end
                cnt_n = cnt_q + CNTW'(1);
                if (cnt_q == LAST_STEP) state_n = S_FIX;
            end
            S_FIX: begin
                result_n = fix_val;
                state_n  = S_DONE;
            end
            S_DONE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_PREP) || (state_n == S_ITER) || (state_n == S_FIX);
        done_n = (state_n == S_DONE);
        // ALU operands are registered so they present the coming step's values.
        if (state_n == S_ITER) begin
            alu_fn_n = is_div ? FN_SUB : FN_ADD;
            alu_a_n  = is_div ? {hi_n[XLEN-2:0], lo_n[XLEN-1]} : hi_n;
            alu_b_n  = mcand_n;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            neg_q   <= 1'b0;
            dz_q    <= 1'b0;
            cnt_q   <= '0;
            result  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_fn  <= FN_ADD;
        end else begin
            state_q <= state_n;
            op_q    <= op_n;
            a_q     <= a_n;
            b_q     <= b_n;
            hi_q    <= hi_n;
            lo_q    <= lo_n;
            mcand_q <= mcand_n;
            neg_q   <= neg_n;
            dz_q    <= dz_n;
            cnt_q   <= cnt_n;
            result  <= result_n;
            busy    <= busy_n;
            done    <= done_n;
            alu_a   <= alu_a_n;
            alu_b   <= alu_b_n;
            alu_fn  <= alu_fn_n;
        end
    end

endmodule

// File: tb/tb_prv32_muldiv_ctrl.sv
// Directed bench for prv32_muldiv_ctrl with a behavioural add/sub ALU attached.
module tb_prv32_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs1, rs2;
    logic        busy, done;
    logic [31:0] result, alu_a, alu_b, alu_r;
    logic [3:0]  alu_fn;
    logic        alu_cf;
    logic [32:0] alu_sum;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PRV32_MULDIV_EARLY_OUT_EN
    localparam int LAT_EXC = 1;
`else
    localparam int LAT_EXC = 34;
`endif
    localparam int LAT = 34;

    always #5 clk = ~clk;

    prv32_muldiv_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .rs1    (rs1),
        .rs2    (rs2),
        .busy   (busy),
        .done   (done),
        .result (result),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_fn (alu_fn),
        .alu_r  (alu_r),
        .alu_cf (alu_cf)
    );

    // Reference ALU: carry out of a+b, or of a+~b+1 for subtract.
    always_comb begin
        if (alu_fn == 4'b0001) alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + 33'd1;
        else                   alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_r  = alu_sum[31:0];
    assign alu_cf = alu_sum[32];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one request and check its latency, busy span, result, and that a start in DONE is ignored.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                          input int inj);
        int   k;
        int   bcnt;
        logic seen;
        @(negedge clk);
        start = 1'b1; op = f3; rs1 = a; rs2 = b;
        @(posedge clk); #1;
        start = 1'b0; rs1 = 32'hDEAD_BEEF; rs2 = 32'h1234_5678;
        k = 0; bcnt = int'(busy); seen = 1'b0;
        while (k < 60 && !seen) begin
            @(posedge clk); #1;
            k++;
            if (start) start = 1'b0;
            if (done) begin
                seen = 1'b1;
            end else begin
                bcnt += int'(busy);
                if (k == inj) begin
                    start = 1'b1; op = 3'b100; rs1 = 32'd100; rs2 = 32'd3;
                end
            end
            if (k == 5 && exp_lat > 2)
                check({tag, " alu_fn"}, 32'(alu_fn), f3[2] ? 32'd1 : 32'd0);
        end
        check({tag, " latency"}, 32'(k), 32'(exp_lat));
        check({tag, " busy_cycles"}, 32'(bcnt), 32'(exp_lat));
        check({tag, " result"}, result, exp);
        start = 1'b1; op = 3'b000; rs1 = 32'd1; rs2 = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " done_pulse"}, 32'(done), 32'd0);
        check({tag, " idle_busy"}, 32'(busy), 32'd0);
        check({tag, " held"}, result, exp);
        check({tag, " idle_alu_a"}, alu_a, 32'd0);
        @(posedge clk); #1;
        check({tag, " start_in_done"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        rst_n = 1'b0; start = 1'b0; op = 3'b000; rs1 = '0; rs2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst result", result, 32'd0);
        check("rst alu_a", alu_a, 32'd0);
        check("rst alu_b", alu_b, 32'd0);
        check("rst alu_fn", 32'(alu_fn), 32'd0);
        @(negedge clk); rst_n = 1'b1;

        run_op("mul",       3'b000, 32'd7,         32'd6,         32'h0000_002A, LAT, 0);
        run_op("mul_inj",   3'b000, 32'd7,         32'd6,         32'h0000_002A, LAT, 5);
        run_op("mul_neg",   3'b000, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFA, LAT, 0);
        run_op("mulh",      3'b001, 32'hFFFF_FFFD, 32'd2,         32'hFFFF_FFFF, LAT, 0);
        run_op("mulh_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, LAT, 0);
        run_op("mulhu",     3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, LAT, 0);
        run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, LAT, 0);
        run_op("div",       3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, LAT, 0);
        run_op("rem",       3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, LAT, 0);
        run_op("divu",      3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 32'h0000_0001, LAT, 0);
        run_op("remu",      3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, LAT, 0);
        run_op("divu_z",    3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, LAT_EXC, 0);
        run_op("rem_z",     3'b110, 32'd5,         32'd0,         32'h0000_0005, LAT_EXC, 0);
        run_op("div_negz",  3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, LAT_EXC, 0);
        run_op("rem_negz",  3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, LAT_EXC, 0);
        run_op("div_ovf",   3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_EXC, 0);
        run_op("rem_ovf",   3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, LAT_EXC, 0);

        // Reset in the middle of ITER abandons the operation.
        @(negedge clk);
        start = 1'b1; op = 3'b000; rs1 = 32'd7; rs2 = 32'd6;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst alu_a", alu_a, 32'd0);
        check("midrst alu_fn", 32'(alu_fn), 32'd0);
        @(negedge clk); rst_n = 1'b1;
        dcnt = 0;
        repeat (40) begin
            @(posedge clk); #1;
            dcnt += int'(done) + int'(busy);
        end
        check("midrst no_done", 32'(dcnt), 32'd0);

        run_op("mul_after_rst", 3'b000, 32'd3, 32'd3, 32'h0000_0009, LAT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
